// File: rtl/key_pkg.sv
// Shared definitions for the key debounce path: FSM state encoding and
// default timing constants for a 50 MHz system clock.
package key_pkg;

  localparam int CLK_FREQ_HZ  = 50_000_000;
  localparam int CNT_MAX_20MS = CLK_FREQ_HZ / 50;
  localparam int LONG_1S      = CLK_FREQ_HZ;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both stages
// reset to RST_VAL so the downstream logic sees an idle level after reset.
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync1_q;
  logic sync2_q;

  // Metastability chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/key_filter.sv
// Push-button debouncer: synchronizes the raw key, filters it through a
// four-state FSM and emits a clean level plus press/release/long/toggle events.
module key_filter
  import key_pkg::*;
#(
  parameter int   CNT_MAX      = CNT_MAX_20MS,
  parameter int   LONG_CNT_MAX = LONG_1S,
  parameter logic KEY_ACTIVE   = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_value,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_toggle
);

  localparam int CW = $clog2(CNT_MAX);
  localparam int LW = $clog2(LONG_CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
  localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CNT_MAX - 1);
  localparam logic [LW-1:0] LCNT_PRE  = LW'(LONG_CNT_MAX - 2);

  logic       sync2_s;
  logic       key_hit_s;
  key_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic value_q, value_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;
  logic toggle_q, toggle_d;

  key_sync #(
    .RST_VAL (~KEY_ACTIVE)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (key_in),
    .q     (sync2_s)
  );

  assign key_hit_s = (sync2_s == KEY_ACTIVE);

  // Next-state, counter and output-event decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lcnt_d    = lcnt_q;
    value_d   = value_q;
    toggle_d  = toggle_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        lcnt_d = '0;
        if (key_hit_s) begin
          state_d = PRESS_FILT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESS_FILT: begin
        if (!key_hit_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DOWN;
          cnt_d    = '0;
          lcnt_d   = '0;
          press_d  = 1'b1;
          value_d  = 1'b1;
          toggle_d = ~toggle_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOWN: begin
        // lcnt saturates, so the long event can only fire once per press.
        if (lcnt_q != LCNT_LAST) begin
          lcnt_d = lcnt_q + LW'(1);
          long_d = (lcnt_q == LCNT_PRE);
        end else begin
          lcnt_d = lcnt_q;
        end
        if (!key_hit_s) begin
          state_d = REL_FILT;
          cnt_d   = '0;
        end else begin
          state_d = DOWN;
        end
      end
      REL_FILT: begin
        if (key_hit_s) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          lcnt_d    = '0;
          release_d = 1'b1;
          value_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        lcnt_d  = '0;
        value_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lcnt_q    <= '0;
      value_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lcnt_q    <= lcnt_d;
      value_q   <= value_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      toggle_q  <= toggle_d;
    end
  end

  assign key_value   = value_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign key_toggle  = toggle_q;

endmodule
